// File: rtl/alu_pkg.sv
// Shared types for the ALU command-issue stage: opcodes, command payload, FSM states.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    SLL = 3'b010,
    LSR = 3'b011,
    AND = 3'b100,
    OR  = 3'b101,
    XOR = 3'b110,
    EQL = 3'b111
  } alu_op_t;

  typedef struct packed {
    alu_op_t           op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              chain;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command and result handshake bundle between a producer/consumer and the issuer.
interface alu_cmd_issuer_if #(
  parameter int unsigned TAG_W = 4
);
  import alu_pkg::*;

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [OP_W-1:0]      cmd_op_i;
  logic [DATA_W-1:0]    cmd_a_i;
  logic [DATA_W-1:0]    cmd_b_i;
  logic                 cmd_chain_i;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [DATA_W-1:0]    res_data_o;
  logic [TAG_W-1:0]     res_tag_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_chain_i, res_ready_i,
    output cmd_ready_o, res_valid_o, res_data_o, res_tag_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_chain_i, res_ready_i,
    input  cmd_ready_o, res_valid_o, res_data_o, res_tag_o
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_push,
  input  alu_cmd_t i_wdata,
  input  logic     i_pop,
  output alu_cmd_t o_rdata,
  output logic     o_full,
  output logic     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  alu_cmd_t       r_mem [DEPTH];
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues buffered commands onto a combinational ALU and captures tagged results.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_cmd_issuer_if.slave   bus,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [OP_W-1:0]   op_o,
  input  logic [DATA_W-1:0] alu_i,
  output logic              busy_o
);

  issue_state_t      r_state;
  issue_state_t      w_state_nxt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  alu_op_t           r_op;
  logic [DATA_W-1:0] r_res_data;
  logic [DATA_W-1:0] r_last_res;
  logic [TAG_W-1:0]  r_res_tag;
  logic [TAG_W-1:0]  r_tag_cnt;
  logic              r_res_valid;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_capture;
  logic              w_clr_valid;
  logic [DATA_W-1:0] w_last_res;
  alu_cmd_t          w_wdata;
  alu_cmd_t          w_head;

  assign w_push  = bus.cmd_valid_i && !w_full;
  assign w_wdata = '{op: alu_op_t'(bus.cmd_op_i), a: bus.cmd_a_i,
                     b: bus.cmd_b_i, chain: bus.cmd_chain_i};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_clr_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.res_ready_i) begin
          w_clr_valid = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = CAPTURE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Forward a result captured on the same edge so a chained load never sees a stale value.
  assign w_last_res = w_capture ? alu_i : r_last_res;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= ADD;
      r_res_data  <= '0;
      r_last_res  <= '0;
      r_res_tag   <= '0;
      r_tag_cnt   <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_a  <= w_head.chain ? w_last_res : w_head.a;
        r_b  <= w_head.b;
        r_op <= w_head.op;
      end
      if (w_capture) begin
        r_res_data  <= alu_i;
        r_last_res  <= alu_i;
        r_res_tag   <= r_tag_cnt;
        r_tag_cnt   <= r_tag_cnt + TAG_W'(1);
        r_res_valid <= 1'b1;
      end else if (w_clr_valid) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign a_o             = r_a;
  assign b_o             = r_b;
  assign op_o            = r_op;
  assign bus.cmd_ready_o = !w_full;
  assign bus.res_valid_o = r_res_valid;
  assign bus.res_data_o  = r_res_data;
  assign bus.res_tag_o   = r_res_tag;
  assign busy_o          = !w_empty || (r_state != IDLE);

endmodule
